sfx_tone_gen: RTL and testbench

Programmable square-wave sound-effect generator for the game audio path. It accepts one tone command at a time through a valid/ready handshake. Each command sets pitch, duration, volume and a linear pitch sweep, which covers jump, score and game-over sounds. The block drives a signed 16-bit sample toward the audio codec interface, outputs true silence (0) when idle, and reports completion with a one-cycle `done` pulse.

---
 rtl/sfx_tone_gen.sv | 147 ++++++++++++++
 tb/tb_sfx_tone_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_tone_gen.sv
// Square-wave sound-effect generator: one command at a time, optional linear pitch sweep,
// symmetric amplitude with shift-based volume, true silence when idle.
module sfx_tone_gen #(
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 12,
    parameter int SWEEP_W  = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [PERIOD_W-1:0]        cmd_half_period,
    input  logic [DUR_W-1:0]           cmd_duration,
    input  logic signed [SWEEP_W-1:0]  cmd_sweep,
    input  logic [2:0]                 cmd_volume,
    input  logic                       stop,
    output logic signed [15:0]         audio_out,
    output logic                       busy,
    output logic                       done
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0]              TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PERIOD_W-1:0]        HALF_MIN  = PERIOD_W'(2);
    localparam logic signed [PERIOD_W+1:0] SUM_MIN   = (PERIOD_W+2)'(2);
    localparam logic signed [PERIOD_W+1:0] SUM_MAX   = $signed({2'b00, {PERIOD_W{1'b1}}});
    localparam logic signed [15:0]         AMP_MAX   = 16'sh7FFF;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t               state_q, state_d;
    logic [PERIOD_W-1:0]  half_q, half_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [DUR_W-1:0]     remaining_q, remaining_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [SWEEP_W-1:0]   sweep_q, sweep_d;
    logic [2:0]           volume_q, volume_d;
    logic                 phase_q, phase_d;
    logic signed [15:0]   audio_q, audio_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                       accept;
    logic signed [PERIOD_W+1:0] half_sum;
    logic signed [15:0]         amp;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        tick_cnt_d  = tick_cnt_q;
        sweep_d     = sweep_q;
        volume_d    = volume_q;
        phase_d     = phase_q;
        done_d      = 1'b0;
        // Sign-extended sweep added with two guard bits so both under- and overflow are visible.
        half_sum    = $signed({2'b00, half_q})
                    + $signed({{(PERIOD_W+2-SWEEP_W){sweep_q[SWEEP_W-1]}}, sweep_q});

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sweep_d  = cmd_sweep;
                    volume_d = cmd_volume;
                    if (cmd_duration != '0) begin
                        state_d     = PLAY;
                        half_d      = (cmd_half_period < HALF_MIN) ? HALF_MIN : cmd_half_period;
                        remaining_d = cmd_duration;
                        phase_d     = 1'b1;
                        cnt_d       = '0;
                        tick_cnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    // >= so a half that just shrank below cnt ends the level at once.
                    if (cnt_q >= half_q - PERIOD_W'(1)) begin
                        cnt_d   = '0;
                        phase_d = !phase_q;
                    end else begin
                        cnt_d = cnt_q + PERIOD_W'(1);
                    end
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d  = '0;
                        remaining_d = remaining_q - DUR_W'(1);
                        if (half_sum < SUM_MIN)      half_d = HALF_MIN;
                        else if (half_sum > SUM_MAX) half_d = '1;
                        else                         half_d = half_sum[PERIOD_W-1:0];
                        if (remaining_q == DUR_W'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        amp     = AMP_MAX >>> volume_d;
        busy_d  = (state_d == PLAY);
        audio_d = (state_d == PLAY) ? (phase_d ? amp : -amp) : 16'sd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            half_q      <= '0;
            cnt_q       <= '0;
            remaining_q <= '0;
            tick_cnt_q  <= '0;
            sweep_q     <= '0;
            volume_q    <= '0;
            phase_q     <= 1'b0;
            audio_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            tick_cnt_q  <= tick_cnt_d;
            sweep_q     <= sweep_d;
            volume_q    <= volume_d;
            phase_q     <= phase_d;
            audio_q     <= audio_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign audio_out = audio_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_sfx_tone_gen.sv
// Directed bench for sfx_tone_gen with TICK_DIV = 10; expected waveforms are hand-derived.
module tb_sfx_tone_gen;
    localparam int TD = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [19:0]        cmd_half_period = '0;
    logic [11:0]        cmd_duration = '0;
    logic signed [7:0]  cmd_sweep = '0;
    logic [2:0]         cmd_volume = '0;
    logic               stop = 1'b0;
    logic signed [15:0] audio_out;
    logic               busy;
    logic               done;

    int total = 0;
    int bad = 0;

    sfx_tone_gen #(.PERIOD_W(20), .DUR_W(12), .SWEEP_W(8), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_half_period(cmd_half_period), .cmd_duration(cmd_duration),
        .cmd_sweep(cmd_sweep), .cmd_volume(cmd_volume), .stop(stop),
        .audio_out(audio_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the accept edge.
    task automatic issue_cmd(input int h, input int d, input int sw, input int vol);
        cmd_half_period = 20'(h);
        cmd_duration    = 12'(d);
        cmd_sweep       = 8'(sw);
        cmd_volume      = 3'(vol);
        cmd_valid       = 1'b1;
        for (int i = 0; i < 200 && !cmd_ready; i++) step();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_cmd_ready: got %b want 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    // Called just after the accept edge; walks the whole tone without sweep.
    task automatic play_check(input string nm, input int h, input int d, input int amp);
        logic signed [15:0] exp_a;
        for (int k = 0; k <= d * TD; k++) begin
            if (k < d * TD) begin
                exp_a = (((k / h) % 2) == 0) ? 16'(amp) : 16'(-amp);
                total++;
                if (audio_out !== exp_a || busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL %s k=%0d: audio=%0d busy=%b done=%b want audio=%0d busy=1 done=0",
                             nm, k, audio_out, busy, done, exp_a);
                end
            end else begin
                total++;
                if (audio_out !== 16'sd0 || busy !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_end k=%0d: audio=%0d busy=%b done=%b ready=%b want 0 0 1 1",
                             nm, k, audio_out, busy, done, cmd_ready);
                end
            end
            if (k < d * TD) step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        total++;
        if (audio_out !== 16'sd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: audio=%0d busy=%b done=%b ready=%b want 0 0 0 0",
                     audio_out, busy, done, cmd_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (audio_out !== 16'sd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle: audio=%0d busy=%b done=%b ready=%b want 0 0 0 1",
                     audio_out, busy, done, cmd_ready);
        end
    endtask

    task automatic test_basic();
        issue_cmd(5, 3, 0, 0);
        play_check("basic", 5, 3, 32767);
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_width: done=%b want 0", done);
        end
    endtask

    task automatic test_half_min();
        issue_cmd(1, 2, 0, 7);
        play_check("half_min", 2, 2, 255);
        step();
    endtask

    task automatic test_sweep();
        int bounds [9] = '{12, 21, 25, 29, 31, 33, 35, 37, 39};
        int n;
        logic signed [15:0] exp_a;
        issue_cmd(20, 4, -8, 0);
        for (int k = 0; k <= 4 * TD; k++) begin
            n = 0;
            foreach (bounds[i]) if (k >= bounds[i]) n++;
            exp_a = (k == 4 * TD) ? 16'sd0 : ((n % 2 == 0) ? 16'sd32767 : -16'sd32767);
            total++;
            if (audio_out !== exp_a || done !== (k == 4 * TD)) begin
                bad++;
                $display("FAIL sweep k=%0d: audio=%0d done=%b want audio=%0d done=%b",
                         k, audio_out, done, exp_a, (k == 4 * TD));
            end
            if (k < 4 * TD) step();
        end
        cmd_sweep = '0;
        step();
    endtask

    task automatic test_stop_with_cmd();
        issue_cmd(5, 3, 0, 0);
        for (int k = 0; k < 6; k++) step();
        cmd_half_period = 20'd3;
        cmd_duration    = 12'd1;
        cmd_volume      = 3'd1;
        cmd_valid       = 1'b1;
        stop            = 1'b1;
        total++;
        if (cmd_ready !== 1'b0 || audio_out !== -16'sd32767) begin
            bad++;
            $display("FAIL stop_pre: ready=%b audio=%0d want ready=0 audio=-32767", cmd_ready, audio_out);
        end
        step();
        stop = 1'b0;
        total++;
        if (audio_out !== 16'sd0 || done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL stop_abort: audio=%0d done=%b busy=%b ready=%b want 0 1 0 1",
                     audio_out, done, busy, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        play_check("stop_next", 3, 1, 16383);
        step();
    endtask

    task automatic test_empty();
        issue_cmd(5, 0, 0, 0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || audio_out !== 16'sd0) begin
            bad++;
            $display("FAIL empty_done: done=%b busy=%b audio=%0d want 1 0 0", done, busy, audio_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || audio_out !== 16'sd0) begin
                bad++;
                $display("FAIL empty_after %0d: done=%b busy=%b audio=%0d want 0 0 0",
                         i, done, busy, audio_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue_cmd(2, 1, 0, 0);
        cmd_half_period = 20'd4;
        cmd_duration    = 12'd1;
        cmd_volume      = 3'd2;
        cmd_valid       = 1'b1;
        play_check("b2b_first", 2, 1, 32767);
        step();
        cmd_valid = 1'b0;
        play_check("b2b_second", 4, 1, 8191);
        step();
    endtask

    task automatic test_reset_mid();
        issue_cmd(5, 3, 0, 0);
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step();
        total++;
        if (audio_out !== 16'sd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: audio=%0d busy=%b done=%b ready=%b want 0 0 0 0",
                     audio_out, busy, done, cmd_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid_after %0d: done=%b busy=%b ready=%b want 0 0 1",
                         i, done, busy, cmd_ready);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_half_min();
        test_sweep();
        test_stop_with_cmd();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
